bcd_updown_counter4: RTL and testbench
======================================

Name: bcd_updown_counter4

Overview:
- Four-digit BCD up/down counter; the registered source of value0..value3 and the consumer of increase_en/decrease_en.
- Sits in the timer datapath between the 1 Hz tick divider and the 7-segment scan driver.
- Steps one count per tick in the direction the enables select.
- Stops at the terminal count and signals done.

Parameters:
- SEC_MODE, 0, 1: value1 is a tens-of-seconds digit (range 0-5, max count 99:59); 0: plain decimal (max count 9999).

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous, active-high reset
- tick  input  1  one-cycle count strobe from the divider
- load  input  1  one-cycle load strobe
- load_value0..load_value3  input  4 each  BCD preset digits; digit 0 is the LSD
- increase_en  input  1  count-up enable
- decrease_en  input  1  count-down enable
- value0..value3  output  4 each  current BCD digits (registered)
- counting  output  1  high while state is RUN
- done  output  1  one-cycle pulse when the terminal count is reached

Behaviour:
- Clock and reset: one clock (clk); reset is synchronous and active-high (rst). All state updates on the rising edge of clk.
- Reset: value0..3=0, state=IDLE, counting=0, done=0, reload register=0. Reset overrides every other input, including mid-count.
- States:
  - IDLE: armed, not counting.
  - RUN: stepping.
  - DONE: terminal count reached, frozen.
- Load priority: load outranks tick in every state.
- Load action:
  - Digits are clamped: any digit >9 becomes 9; in SEC_MODE, load_value1 >5 becomes 5.
  - The clamped value is written to value0..3 and to the reload register.
  - State goes to IDLE and done=0.
- Legal step: tick=1 and exactly one of increase_en/decrease_en is 1.
- Illegal combinations, hold (no change):
  - Both enables 1.
  - Both enables 0.
  - tick=0.
- IDLE: a legal step moves the state to RUN and applies the step in that same cycle.
- RUN: a legal step applies the step; otherwise values hold.
- Up step:
  - BCD increment with ripple carry.
  - A digit at its max (9, or 5 for value1 in SEC_MODE) wraps to 0 and carries into the next digit.
- Down step:
  - BCD decrement with ripple borrow.
  - A digit at 0 wraps to its max and borrows from the next digit.
- Terminal counts:
  - Up: the step result equals max (9999, or 9959 in SEC_MODE).
  - Down: the step result equals 0000.
  - On the terminal step, the state goes to DONE and done=1 for exactly the one cycle after that edge.
- Saturation: counting never proceeds past max or below 0000. A step requested while already at the terminal value for its direction is ignored: no done pulse, and the state goes to DONE.
- DONE: ticks are ignored and values hold. Only load or rst exits DONE.
- Latency: a step on edge N is visible on value* after edge N. The scan driver and the enable generator see the new value in the following cycle. The enables drop combinationally at 0000.
- counting = (state == RUN); registered, updates on the same edge as the state.
- Direction change mid-RUN: allowed. Each tick uses the enables sampled in that cycle.

Optional Feature:
- Macro: BCD_COUNTER_AUTO_RELOAD_EN.
- Defined:
  - On a down terminal step, done pulses as usual.
  - On the same edge, value0..3 are loaded from the reload register instead of 0000, and the state stays RUN.
  - If the reload register is 0000, the block behaves as if the macro were undefined.
  - Up terminal behaviour is unchanged.
- Undefined: no reload register is synthesised; a down terminal step leaves 0000 and enters DONE.

Test Plan:
- Reset mid-count: count at 0042 in RUN, assert rst one cycle -> next cycle value=0000, counting=0, done=0; later ticks with decrease_en=1 do not change the value until a load.
- Down count with borrow: load 0100, decrease_en=1, 3 ticks -> 0099, 0098, 0097; counting=1 after the first tick.
- Down to zero: load 0002, decrease_en=1, ticks -> 0001, then 0000 with done high for exactly one cycle; state DONE; further ticks hold 0000. With the macro defined: value returns to 0002, counting stays 1.
- Up count, SEC_MODE=1: load 0059, increase_en=1, tick -> 0100. Load 9958, tick -> 9959 with a done pulse; the next tick holds 9959.
- Load and enable conflicts:
  - load 0123 and tick in the same cycle -> value=0123, state IDLE.
  - Load digits {value1=7} with SEC_MODE=1 -> value1 clamps to 5.
  - Both enables high with tick -> no change.
- Direction reversal: load 0050, increase_en=1 for 2 ticks -> 0052; then decrease_en=1 for 3 ticks -> 0049; no done pulse throughout.

Source files
------------

// File: rtl/bcd_updown_counter4.sv
// Four-digit BCD up/down counter with clamped preset load, terminal-count stop and one-cycle done pulse.
// Define BCD_COUNTER_AUTO_RELOAD_EN to restart from the last loaded value on a down terminal count.
module bcd_updown_counter4 #(
  parameter int SEC_MODE = 0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick,
  input  logic       load,
  input  logic [3:0] load_value0,
  input  logic [3:0] load_value1,
  input  logic [3:0] load_value2,
  input  logic [3:0] load_value3,
  input  logic       increase_en,
  input  logic       decrease_en,
  output logic [3:0] value0,
  output logic [3:0] value1,
  output logic [3:0] value2,
  output logic [3:0] value3,
  output logic       counting,
  output logic       done
);

  localparam logic [1:0]  ST_IDLE = 2'd0;
  localparam logic [1:0]  ST_RUN  = 2'd1;
  localparam logic [1:0]  ST_DONE = 2'd2;
  localparam logic [3:0]  MAX1    = (SEC_MODE != 0) ? 4'd5 : 4'd9;
  localparam logic [15:0] MAX_VAL = {4'd9, 4'd9, MAX1, 4'd9};

  function automatic logic [3:0] dmax(input int i);
    return (i == 1) ? MAX1 : 4'd9;
  endfunction

  function automatic logic [15:0] bcd_inc(input logic [15:0] v);
    logic [15:0] r;
    logic        carry;
    r     = v;
    carry = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (carry) begin
        if (v[4*i +: 4] == dmax(i)) begin
          r[4*i +: 4] = 4'd0;
        end else begin
          r[4*i +: 4] = v[4*i +: 4] + 4'd1;
          carry       = 1'b0;
        end
      end
    end
    return r;
  endfunction

  function automatic logic [15:0] bcd_dec(input logic [15:0] v);
    logic [15:0] r;
    logic        borrow;
    r      = v;
    borrow = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (borrow) begin
        if (v[4*i +: 4] == 4'd0) begin
          r[4*i +: 4] = dmax(i);
        end else begin
          r[4*i +: 4] = v[4*i +: 4] - 4'd1;
          borrow      = 1'b0;
        end
      end
    end
    return r;
  endfunction

  logic [1:0]  state_q, state_d;
  logic [15:0] val_q, val_d;
  logic        done_q, done_d;
  logic        counting_q;
  logic [15:0] ld_val;
  logic [15:0] inc_val, dec_val;
  logic        step_up, step_dn;
`ifdef BCD_COUNTER_AUTO_RELOAD_EN
  logic [15:0] reload_q, reload_d;
`endif

  always_comb begin
    ld_val = {load_value3, load_value2, load_value1, load_value0};
    for (int i = 0; i < 4; i++) begin
      if (ld_val[4*i +: 4] > dmax(i)) ld_val[4*i +: 4] = dmax(i);
    end
  end

  assign inc_val = bcd_inc(val_q);
  assign dec_val = bcd_dec(val_q);
  assign step_up = tick & increase_en & ~decrease_en;
  assign step_dn = tick & decrease_en & ~increase_en;

  always_comb begin
    val_d   = val_q;
    state_d = state_q;
    done_d  = 1'b0;
`ifdef BCD_COUNTER_AUTO_RELOAD_EN
    reload_d = reload_q;
`endif
    if (load) begin
      val_d   = ld_val;
      state_d = ST_IDLE;
`ifdef BCD_COUNTER_AUTO_RELOAD_EN
      reload_d = ld_val;
`endif
    end else if (state_q != ST_DONE && step_up) begin
      // A step requested from the terminal value freezes without a pulse.
      if (val_q == MAX_VAL) begin
        state_d = ST_DONE;
      end else begin
        val_d   = inc_val;
        state_d = ST_RUN;
        if (inc_val == MAX_VAL) begin
          state_d = ST_DONE;
          done_d  = 1'b1;
        end
      end
    end else if (state_q != ST_DONE && step_dn) begin
      if (val_q == 16'h0000) begin
        state_d = ST_DONE;
      end else begin
        val_d   = dec_val;
        state_d = ST_RUN;
        if (dec_val == 16'h0000) begin
          state_d = ST_DONE;
          done_d  = 1'b1;
`ifdef BCD_COUNTER_AUTO_RELOAD_EN
          if (reload_q != 16'h0000) begin
            val_d   = reload_q;
            state_d = ST_RUN;
          end
`endif
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      val_q      <= 16'h0000;
      done_q     <= 1'b0;
      counting_q <= 1'b0;
`ifdef BCD_COUNTER_AUTO_RELOAD_EN
      reload_q   <= 16'h0000;
`endif
    end else begin
      state_q    <= state_d;
      val_q      <= val_d;
      done_q     <= done_d;
      counting_q <= (state_d == ST_RUN);
`ifdef BCD_COUNTER_AUTO_RELOAD_EN
      reload_q   <= reload_d;
`endif
    end
  end

  assign value0   = val_q[3:0];
  assign value1   = val_q[7:4];
  assign value2   = val_q[11:8];
  assign value3   = val_q[15:12];
  assign counting = counting_q;
  assign done     = done_q;

endmodule

// File: tb/tb_bcd_updown_counter4.sv
// Bench for bcd_updown_counter4: drives a plain-decimal and a SEC_MODE instance with shared stimulus.
// Honours BCD_COUNTER_AUTO_RELOAD_EN when the same macro is defined for the build.
module tb_bcd_updown_counter4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        tick = 1'b0;
  logic        load = 1'b0;
  logic [15:0] lv = 16'h0000;
  logic        increase_en = 1'b0;
  logic        decrease_en = 1'b0;
  logic [3:0]  a0, a1, a2, a3, b0, b1, b2, b3;
  logic        a_cnt, a_done, b_cnt, b_done;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  bcd_updown_counter4 #(.SEC_MODE(0)) u_dec (
    .clk(clk), .rst(rst), .tick(tick), .load(load),
    .load_value0(lv[3:0]), .load_value1(lv[7:4]), .load_value2(lv[11:8]), .load_value3(lv[15:12]),
    .increase_en(increase_en), .decrease_en(decrease_en),
    .value0(a0), .value1(a1), .value2(a2), .value3(a3),
    .counting(a_cnt), .done(a_done)
  );

  bcd_updown_counter4 #(.SEC_MODE(1)) u_sec (
    .clk(clk), .rst(rst), .tick(tick), .load(load),
    .load_value0(lv[3:0]), .load_value1(lv[7:4]), .load_value2(lv[11:8]), .load_value3(lv[15:12]),
    .increase_en(increase_en), .decrease_en(decrease_en),
    .value0(b0), .value1(b1), .value2(b2), .value3(b3),
    .counting(b_cnt), .done(b_done)
  );

  // Reference model: the count is an integer (seconds in SEC_MODE), digits only at the edges.
  int m_n[2];
  int m_st[2];     // 0 idle, 1 run, 2 done
  bit m_done[2];
  int m_rl[2];

  function automatic int maxn(bit sec);
    return sec ? 5999 : 9999;
  endfunction

  function automatic int dig(logic [15:0] v, int i);
    return int'(v[4*i +: 4]);
  endfunction

  function automatic int clamp_to_n(bit sec, logic [15:0] v);
    int d[4];
    for (int i = 0; i < 4; i++) d[i] = (dig(v, i) > 9) ? 9 : dig(v, i);
    if (sec && d[1] > 5) d[1] = 5;
    if (sec) return (d[3] * 10 + d[2]) * 60 + d[1] * 10 + d[0];
    return d[3] * 1000 + d[2] * 100 + d[1] * 10 + d[0];
  endfunction

  function automatic logic [15:0] n_to_bcd(bit sec, int n);
    int hi, lo;
    hi = sec ? n / 60 : n / 100;
    lo = sec ? n % 60 : n % 100;
    return {4'(hi / 10), 4'(hi % 10), 4'(lo / 10), 4'(lo % 10)};
  endfunction

  task automatic model_step(input int k, input bit sec);
    m_done[k] = 1'b0;
    if (rst) begin
      m_n[k] = 0; m_st[k] = 0; m_rl[k] = 0;
    end else if (load) begin
      m_n[k] = clamp_to_n(sec, lv); m_rl[k] = m_n[k]; m_st[k] = 0;
    end else if (tick && (increase_en != decrease_en) && m_st[k] != 2) begin
      if (increase_en) begin
        if (m_n[k] == maxn(sec)) m_st[k] = 2;
        else begin
          m_n[k] += 1;
          m_st[k] = 1;
          if (m_n[k] == maxn(sec)) begin m_st[k] = 2; m_done[k] = 1'b1; end
        end
      end else begin
        if (m_n[k] == 0) m_st[k] = 2;
        else begin
          m_n[k] -= 1;
          m_st[k] = 1;
          if (m_n[k] == 0) begin
            m_st[k] = 2; m_done[k] = 1'b1;
`ifdef BCD_COUNTER_AUTO_RELOAD_EN
            if (m_rl[k] != 0) begin m_n[k] = m_rl[k]; m_st[k] = 1; end
`endif
          end
        end
      end
    end
  endtask

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp);
    end
  endtask

  task automatic check_model();
    chk("dec_model_value", {a3, a2, a1, a0}, n_to_bcd(1'b0, m_n[0]));
    chk("dec_model_counting", 16'(a_cnt), 16'(m_st[0] == 1));
    chk("dec_model_done", 16'(a_done), 16'(m_done[0]));
    chk("sec_model_value", {b3, b2, b1, b0}, n_to_bcd(1'b1, m_n[1]));
    chk("sec_model_counting", 16'(b_cnt), 16'(m_st[1] == 1));
    chk("sec_model_done", 16'(b_done), 16'(m_done[1]));
  endtask

  task automatic apply(input bit r, input bit l, input logic [15:0] v,
                       input bit u, input bit d, input bit t);
    rst = r; load = l; lv = v; increase_en = u; decrease_en = d; tick = t;
    @(posedge clk);
    model_step(0, 1'b0);
    model_step(1, 1'b1);
    #1;
    check_model();
  endtask

  task automatic expect_both(input string nm, input logic [15:0] e0, input bit c0, input bit d0,
                             input logic [15:0] e1, input bit c1, input bit d1);
    chk({nm, "_dec_value"}, {a3, a2, a1, a0}, e0);
    chk({nm, "_dec_counting"}, 16'(a_cnt), 16'(c0));
    chk({nm, "_dec_done"}, 16'(a_done), 16'(d0));
    chk({nm, "_sec_value"}, {b3, b2, b1, b0}, e1);
    chk({nm, "_sec_counting"}, 16'(b_cnt), 16'(c1));
    chk({nm, "_sec_done"}, 16'(b_done), 16'(d1));
  endtask

  typedef struct {
    bit r, l; logic [15:0] v; bit u, d, t;
    logic [15:0] e0; bit c0, d0;
    logic [15:0] e1; bit c1, d1;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(bit r, bit l, logic [15:0] v, bit u, bit d, bit t,
                              logic [15:0] e0, bit c0, bit d0, logic [15:0] e1, bit c1, bit d1);
    vec_t x;
    x.r = r; x.l = l; x.v = v; x.u = u; x.d = d; x.t = t;
    x.e0 = e0; x.c0 = c0; x.d0 = d0; x.e1 = e1; x.c1 = c1; x.d1 = d1;
    return x;
  endfunction

  initial begin
    //             r  l  load     u  d  t   dec exp        sec exp
    tbl.push_back(mk(1, 0, 16'h0000, 0, 0, 0, 16'h0000, 0, 0, 16'h0000, 0, 0));
    tbl.push_back(mk(0, 1, 16'h0059, 0, 0, 0, 16'h0059, 0, 0, 16'h0059, 0, 0));
    tbl.push_back(mk(0, 0, 16'h0000, 1, 0, 1, 16'h0060, 1, 0, 16'h0100, 1, 0));
    tbl.push_back(mk(0, 0, 16'h0000, 1, 0, 1, 16'h0061, 1, 0, 16'h0101, 1, 0));
    tbl.push_back(mk(0, 1, 16'h9958, 0, 0, 0, 16'h9958, 0, 0, 16'h9958, 0, 0));
    tbl.push_back(mk(0, 0, 16'h0000, 1, 0, 1, 16'h9959, 1, 0, 16'h9959, 0, 1));
    tbl.push_back(mk(0, 0, 16'h0000, 1, 0, 1, 16'h9960, 1, 0, 16'h9959, 0, 0));
    tbl.push_back(mk(0, 1, 16'h0123, 1, 0, 1, 16'h0123, 0, 0, 16'h0123, 0, 0));
    tbl.push_back(mk(0, 0, 16'h0000, 1, 1, 1, 16'h0123, 0, 0, 16'h0123, 0, 0));
    tbl.push_back(mk(0, 0, 16'h0000, 0, 0, 1, 16'h0123, 0, 0, 16'h0123, 0, 0));
    tbl.push_back(mk(0, 0, 16'h0000, 1, 0, 0, 16'h0123, 0, 0, 16'h0123, 0, 0));
    tbl.push_back(mk(0, 1, 16'hA7F9, 0, 0, 0, 16'h9799, 0, 0, 16'h9759, 0, 0));
    tbl.push_back(mk(0, 1, 16'h0100, 0, 0, 0, 16'h0100, 0, 0, 16'h0100, 0, 0));
    tbl.push_back(mk(0, 0, 16'h0000, 0, 1, 1, 16'h0099, 1, 0, 16'h0059, 1, 0));
    tbl.push_back(mk(0, 0, 16'h0000, 0, 1, 1, 16'h0098, 1, 0, 16'h0058, 1, 0));
    tbl.push_back(mk(0, 0, 16'h0000, 0, 1, 1, 16'h0097, 1, 0, 16'h0057, 1, 0));
    tbl.push_back(mk(1, 0, 16'h0000, 0, 1, 1, 16'h0000, 0, 0, 16'h0000, 0, 0));
    tbl.push_back(mk(0, 0, 16'h0000, 0, 1, 1, 16'h0000, 0, 0, 16'h0000, 0, 0));
    tbl.push_back(mk(0, 0, 16'h0000, 1, 0, 1, 16'h0000, 0, 0, 16'h0000, 0, 0));
    tbl.push_back(mk(0, 1, 16'h0050, 0, 0, 0, 16'h0050, 0, 0, 16'h0050, 0, 0));
    tbl.push_back(mk(0, 0, 16'h0000, 1, 0, 1, 16'h0051, 1, 0, 16'h0051, 1, 0));
    tbl.push_back(mk(0, 0, 16'h0000, 1, 0, 1, 16'h0052, 1, 0, 16'h0052, 1, 0));
    tbl.push_back(mk(0, 0, 16'h0000, 0, 1, 1, 16'h0051, 1, 0, 16'h0051, 1, 0));
    tbl.push_back(mk(0, 0, 16'h0000, 0, 1, 1, 16'h0050, 1, 0, 16'h0050, 1, 0));
    tbl.push_back(mk(0, 0, 16'h0000, 0, 1, 1, 16'h0049, 1, 0, 16'h0049, 1, 0));
    tbl.push_back(mk(0, 1, 16'h9998, 0, 0, 0, 16'h9998, 0, 0, 16'h9958, 0, 0));
    tbl.push_back(mk(0, 0, 16'h0000, 1, 0, 1, 16'h9999, 0, 1, 16'h9959, 0, 1));
    tbl.push_back(mk(0, 0, 16'h0000, 1, 0, 1, 16'h9999, 0, 0, 16'h9959, 0, 0));
    tbl.push_back(mk(0, 1, 16'h9999, 0, 0, 0, 16'h9999, 0, 0, 16'h9959, 0, 0));
    tbl.push_back(mk(0, 0, 16'h0000, 1, 0, 1, 16'h9999, 0, 0, 16'h9959, 0, 0));

    for (int i = 0; i < tbl.size(); i++) begin
      apply(tbl[i].r, tbl[i].l, tbl[i].v, tbl[i].u, tbl[i].d, tbl[i].t);
      expect_both($sformatf("vec%0d", i), tbl[i].e0, tbl[i].c0, tbl[i].d0,
                  tbl[i].e1, tbl[i].c1, tbl[i].d1);
    end

    // Down to zero: done pulses once; with auto-reload the preset comes back and RUN continues.
    apply(0, 1, 16'h0002, 0, 0, 0);
    apply(0, 0, 16'h0000, 0, 1, 1);
    expect_both("dz1", 16'h0001, 1, 0, 16'h0001, 1, 0);
    apply(0, 0, 16'h0000, 0, 1, 1);
`ifdef BCD_COUNTER_AUTO_RELOAD_EN
    expect_both("dz2", 16'h0002, 1, 1, 16'h0002, 1, 1);
`else
    expect_both("dz2", 16'h0000, 0, 1, 16'h0000, 0, 1);
`endif
    apply(0, 0, 16'h0000, 0, 1, 1);
`ifdef BCD_COUNTER_AUTO_RELOAD_EN
    expect_both("dz3", 16'h0001, 1, 0, 16'h0001, 1, 0);
`else
    expect_both("dz3", 16'h0000, 0, 0, 16'h0000, 0, 0);
`endif
    apply(0, 0, 16'h0000, 0, 0, 0);
    // Zero preset: a down step from 0000 freezes silently even with auto-reload.
    apply(0, 1, 16'h0000, 0, 0, 0);
    apply(0, 0, 16'h0000, 0, 1, 1);
    expect_both("zero_sat", 16'h0000, 0, 0, 16'h0000, 0, 0);

    for (int c = 0; c < 3000; c++) begin
      bit r, l, u, d, t;
      logic [15:0] v;
      r = ($urandom_range(0, 199) == 0);
      l = ($urandom_range(0, 39) == 0);
      v = 16'($urandom);
      if ($urandom_range(0, 1) == 1) v[15:8] = 8'h00;
      else v[15:8] = 8'h99;
      u = 1'($urandom);
      d = 1'($urandom);
      if ($urandom_range(0, 3) != 0) begin
        d = ~u;
      end
      t = ($urandom_range(0, 2) != 0);
      apply(r, l, v, u, d, t);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
